// File: rtl/mips_fetch_unit_if.sv
// rtl/mips_fetch_unit_if.sv - instruction ROM, decode handshake and redirect signals of the fetch unit
interface mips_fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;

  // fetch unit side
  modport master (
    output rom_addr,
    input  rom_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc,
    output halted,
    output fetch_count
  );

  // ROM / decode / branch-unit side
  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect_valid,
    output redirect_pc,
    input  halted,
    output fetch_count
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - PC, 2-entry instruction queue and redirect handling; FETCH_HALT_DETECT_EN enables halt-word stop
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_fetch_unit_if.master bus
);

`ifdef FETCH_HALT_DETECT_EN
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`endif

  typedef enum logic {MODE_RUN, MODE_HALT} mode_e;

  mode_e       mode_q, mode_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] w0_q, w0_d, p0_q, p0_d;  // head entry
  logic [31:0] w1_q, w1_d, p1_q, p1_d;  // second entry
  logic [1:0]  occ_q, occ_d;
  logic [15:0] cnt_q, cnt_d;

  logic        pop;
  logic        push_slot;
  logic        halt_hit;
  logic [1:0]  occ_after_pop;

  // the halt word only ends fetching when detection is built in
`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = (bus.rom_data == HALT_WORD);
`else
  assign halt_hit = 1'b0;
`endif

  // pop/push decisions, queue shift and redirect flush
  always_comb begin
    mode_d        = mode_q;
    pc_d          = pc_q;
    w0_d          = w0_q;
    p0_d          = p0_q;
    w1_d          = w1_q;
    p1_d          = p1_q;
    occ_d         = occ_q;
    cnt_d         = cnt_q;
    pop           = (occ_q != 2'd0) && bus.instr_ready;
    push_slot     = (mode_q == MODE_RUN) && ((occ_q != 2'd2) || pop);
    occ_after_pop = occ_q - {1'b0, pop};

    if (bus.redirect_valid) begin
      // flush wins over everything; a same-cycle pop is simply dropped with the rest
      occ_d  = 2'd0;
      pc_d   = bus.redirect_pc;
      mode_d = MODE_RUN;
    end else begin
      if (pop) begin
        w0_d = w1_q;
        p0_d = p1_q;
      end
      occ_d = occ_after_pop;
      if (push_slot) begin
        if (halt_hit) begin
          mode_d = MODE_HALT;
        end else begin
          if (occ_after_pop == 2'd0) begin
            w0_d = bus.rom_data;
            p0_d = pc_q;
          end else begin
            w1_d = bus.rom_data;
            p1_d = pc_q;
          end
          occ_d = occ_after_pop + 2'd1;
          pc_d  = pc_q + 32'd1;
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RUN;
      pc_q   <= RESET_PC;
      w0_q   <= 32'd0;
      p0_q   <= 32'd0;
      w1_q   <= 32'd0;
      p1_q   <= 32'd0;
      occ_q  <= 2'd0;
      cnt_q  <= 16'd0;
    end else begin
      mode_q <= mode_d;
      pc_q   <= pc_d;
      w0_q   <= w0_d;
      p0_q   <= p0_d;
      w1_q   <= w1_d;
      p1_q   <= p1_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr_valid = (occ_q != 2'd0);
  assign bus.instr       = (occ_q != 2'd0) ? w0_q : 32'd0;
  assign bus.instr_pc    = (occ_q != 2'd0) ? p0_q : 32'd0;
  assign bus.fetch_count = cnt_q;
  assign bus.halted      = (mode_q == MODE_HALT);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - randomized bench for mips_fetch_unit against a queue-based reference model
module tb_mips_fetch_unit;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_DET = 1'b1;
`else
  localparam bit HALT_DET = 1'b0;
`endif

  logic clk;
  logic rst_n;
  mips_fetch_unit_if bus ();

  mips_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom_mem [64];

  // combinational ROM
  assign bus.rom_data = (bus.rom_addr < 32'd64) ? rom_mem[bus.rom_addr[5:0]]
                                                : (bus.rom_addr ^ 32'hA5A5_0000);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] p;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  logic [15:0] m_cnt;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd64) return rom_mem[a[5:0]];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    m_cnt  = 16'h0;
  endtask

  // one clock edge of the architectural behaviour
  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit          pop;
    bit          was_full;
    logic [31:0] w;
    ent_t        e;
    pop      = (m_q.size() > 0) && rdy;
    was_full = (m_q.size() == 2);
    if (pop) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
      return;
    end
    if (!m_halt && (!was_full || pop)) begin
      w = rom_word(m_pc);
      if (HALT_DET && w == 32'hFFFF_FFFF) begin
        m_halt = 1'b1;
      end else begin
        e.w = w;
        e.p = m_pc;
        m_q.push_back(e);
        m_pc  = m_pc + 32'd1;
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic check_all();
    check("rom_addr", bus.rom_addr, m_pc);
    check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_q.size() > 0});
    check("instr", bus.instr, (m_q.size() > 0) ? m_q[0].w : 32'd0);
    check("instr_pc", bus.instr_pc, (m_q.size() > 0) ? m_q[0].p : 32'd0);
    check("halted", {31'd0, bus.halted}, {31'd0, m_halt});
    check("fetch_count", {16'd0, bus.fetch_count}, {16'd0, m_cnt});
  endtask

  // drive inputs at a negedge, step through the rising edge, check at the next negedge
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    model_step(rdy, rv, rpc);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = $urandom();
      if (rom_mem[i] == 32'hFFFF_FFFF) rom_mem[i] = 32'h0;
    end
    rom_mem[0]  = 32'h8C01_007F;
    rom_mem[1]  = 32'h8C02_0082;
    rom_mem[9]  = 32'hFFFF_FFFF;
    rom_mem[31] = 32'h0003_0800;

    // reset values and first fetches
    do_reset();
    check("rst_rom_addr", bus.rom_addr, 32'h0);
    check("rst_fetch_count", {16'd0, bus.fetch_count}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("first_instr", bus.instr, 32'h8C01_007F);
    check("first_pc", bus.instr_pc, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("second_instr", bus.instr, 32'h8C02_0082);
    check("second_pc", bus.instr_pc, 32'h1);
    check("count_two", {16'd0, bus.fetch_count}, 32'd2);

    // stall with ready low, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    check("stall_rom_addr", bus.rom_addr, 32'h2);
    check("stall_head_pc", bus.instr_pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("drain_pc", bus.instr_pc, i);
    end

    // redirect with full queue and same-cycle pop
    cycle(1'b1, 1'b1, 32'h1F);
    check("redir_valid", {31'd0, bus.instr_valid}, 32'h0);
    check("redir_rom_addr", bus.rom_addr, 32'h1F);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir_instr", bus.instr, 32'h0003_0800);
    check("redir_pc", bus.instr_pc, 32'h1F);

    // halt word at address 9
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
    if (HALT_DET) begin
      check("halt_flag", {31'd0, bus.halted}, 32'h1);
      check("halt_rom_addr", bus.rom_addr, 32'h9);
      check("halt_count", {16'd0, bus.fetch_count}, 32'd9);
    end else begin
      check("nohalt_word", bus.instr, 32'hFFFF_FFFF);
      check("nohalt_pc", bus.instr_pc, 32'h9);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check("halt_hold_addr", bus.rom_addr, HALT_DET ? 32'h9 : 32'd13);
    check("halt_hold_flag", {31'd0, bus.halted}, {31'd0, HALT_DET});
    cycle(1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("refetch_instr", bus.instr, 32'h8C01_007F);
    check("refetch_halted", {31'd0, bus.halted}, 32'h0);

    // asynchronous reset mid-stream with one entry queued and pc at 5
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);
    check("pre_rst_addr", bus.rom_addr, 32'h5);
    check("pre_rst_valid", {31'd0, bus.instr_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rom_addr", bus.rom_addr, 32'h0);
    check("async_valid", {31'd0, bus.instr_valid}, 32'h0);
    check("async_instr", bus.instr, 32'h0);
    check("async_count", {16'd0, bus.fetch_count}, 32'h0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h0);
    check("restart_instr", bus.instr, 32'h8C01_007F);

    // randomized traffic including redirects near the 32-bit wrap
    for (int i = 0; i < 3000; i++) begin
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 5);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 63));
      cycle(rdy, rv, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
